// File: rtl/speriph_arb_pkg.sv
// speriph_arb_pkg: shared plug index type and cyclic round-robin winner search
package speriph_arb_pkg;
  localparam int MAX_PLUGS = 16;
  typedef logic [$clog2(MAX_PLUGS)-1:0] plug_idx_t;
  function automatic plug_idx_t rr_next(input plug_idx_t ptr, input logic [MAX_PLUGS-1:0] req, input int unsigned n);
    plug_idx_t w;
    logic f;
    int unsigned i;
    w = '0;
    f = 1'b0;
    for (int unsigned k = 0; k < MAX_PLUGS; k++) begin
      i = (32'(ptr) + k) % n;
      if (k < n && !f && req[plug_idx_t'(i)]) begin
        w = plug_idx_t'(i);
        f = 1'b1;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/speriph_plug_arbiter_if.sv
// speriph_plug_arbiter_if: N-lane peripheral request/response bundle with master/slave views
interface speriph_plug_arbiter_if #(
  parameter int N = 1,
  parameter int ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N-1:0] req, wen, gnt, r_valid, r_opc;
  logic [N-1:0][ADDR_WIDTH-1:0] add;
  logic [N-1:0][DATA_WIDTH-1:0] wdata, r_rdata;
  logic [N-1:0][DATA_WIDTH/8-1:0] be;
  logic [N-1:0][ID_WIDTH-1:0] id, r_id;
  modport master (output req, add, wen, wdata, be, id, input gnt, r_valid, r_rdata, r_opc, r_id);
  modport slave (input req, add, wen, wdata, be, id, output gnt, r_valid, r_rdata, r_opc, r_id);
endinterface

// File: rtl/speriph_arb_resp_fifo.sv
// speriph_arb_resp_fifo: in-order tracking fifo with concurrent push/pop allowed when full
module speriph_arb_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
endmodule

// File: rtl/speriph_plug_arbiter.sv
// speriph_plug_arbiter: round-robin merge of plugs onto one peripheral port; SPERIPH_ARB_STALL_CNT_EN adds stall_cnt_o
module speriph_plug_arbiter
  import speriph_arb_pkg::*;
#(
  parameter int NB_PLUGS = 2,
  parameter int ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic clk_i,
  input logic rst_i,
  speriph_plug_arbiter_if.slave plug,
  speriph_plug_arbiter_if.master per
`ifdef SPERIPH_ARB_STALL_CNT_EN
  , output logic [31:0] stall_cnt_o
`endif
);
  localparam int IW = $clog2(NB_PLUGS);
  logic [IW-1:0] rr_ptr, win, head;
  logic full, empty, pop, fire, err;
  assign win = IW'(rr_next(plug_idx_t'(rr_ptr), MAX_PLUGS'(plug.req), NB_PLUGS));
  assign pop = per.r_valid[0] & ~empty;
  assign per.req[0] = |plug.req & (~full | pop);
  assign fire = per.req[0] & per.gnt[0];
  assign per.add[0] = plug.add[win];
  assign per.wen[0] = plug.wen[win];
  assign per.wdata[0] = plug.wdata[win];
  assign per.be[0] = plug.be[win];
  assign per.id[0] = plug.id[win];
  assign plug.gnt = fire ? NB_PLUGS'(1) << win : '0;
  assign plug.r_valid = pop ? NB_PLUGS'(1) << head : '0;
  assign plug.r_rdata = {NB_PLUGS{per.r_rdata[0]}};
  assign plug.r_opc = {NB_PLUGS{per.r_opc[0]}};
  assign plug.r_id = {NB_PLUGS{per.r_id[0]}};
  speriph_arb_resp_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(IW)) u_fifo (
    .clk(clk_i), .rst(rst_i), .push(fire), .pop(pop), .din(win), .head(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr <= '0;
    else if (fire) rr_ptr <= win == IW'(NB_PLUGS - 1) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) err <= 1'b0;
    else if (per.r_valid[0] & empty) err <= 1'b1;
  end
  assert property (@(posedge clk_i) disable iff (rst_i) err |=> err);
`ifdef SPERIPH_ARB_STALL_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (|plug.req && !fire && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`endif
endmodule

// File: tb/tb_speriph_plug_arbiter.sv
// tb_speriph_plug_arbiter: directed self-checking bench for the round-robin plug arbiter
module tb_speriph_plug_arbiter;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0;
  int failures = 0;
  localparam logic [4:0] ID0 = 5'h03, ID1 = 5'h11;
  localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0004;
  speriph_plug_arbiter_if #(.N(2), .ID_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32)) plug_bus ();
  speriph_plug_arbiter_if #(.N(1), .ID_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32)) per_bus ();
`ifdef SPERIPH_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  speriph_plug_arbiter #(.NB_PLUGS(2), .ID_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .plug(plug_bus),
    .per(per_bus)
`ifdef SPERIPH_ARB_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    #1;
    checks++; if (per_bus.req !== 1'b0) begin failures++; $display("FAIL rst_per_req got=%b exp=0", per_bus.req); end
    checks++; if (plug_bus.gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", plug_bus.gnt); end
    checks++; if (plug_bus.r_valid !== 2'b00) begin failures++; $display("FAIL rst_r_valid got=%b exp=00", plug_bus.r_valid); end
    checks++; if (per_bus.add[0] !== A0 || per_bus.id[0] !== ID0) begin failures++; $display("FAIL rst_fields add=%h id=%h exp add=%h id=%h", per_bus.add[0], per_bus.id[0], A0, ID0); end
    checks++; if (dut.rr_ptr !== 1'b0) begin failures++; $display("FAIL rst_ptr got=%0d exp=0", dut.rr_ptr); end
    rst_i = 1'b0;
    step();
  endtask
  task automatic test_round_robin();
    logic [1:0] eg, ev;
    plug_bus.req = 2'b11;
    per_bus.gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) plug_bus.req = 2'b00;
      per_bus.r_valid = (k > 0);
      per_bus.r_id[0] = ((k - 1) % 2 == 0) ? ID0 : ID1;
      per_bus.r_rdata[0] = 32'hD000_0000 + 32'(k);
      #1;
      eg = (k == 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      ev = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (plug_bus.gnt !== eg) begin failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, plug_bus.gnt, eg); end
      checks++; if (plug_bus.r_valid !== ev) begin failures++; $display("FAIL rr_r_valid k=%0d got=%b exp=%b", k, plug_bus.r_valid, ev); end
      if (k < 4) begin
        checks++; if (per_bus.id[0] !== ((k % 2 == 0) ? ID0 : ID1)) begin failures++; $display("FAIL rr_per_id k=%0d got=%h", k, per_bus.id[0]); end
      end
      if (k > 0) begin
        checks++; if (plug_bus.r_id !== {2{((k - 1) % 2 == 0) ? ID0 : ID1}} || plug_bus.r_rdata[1] !== 32'hD000_0000 + 32'(k)) begin failures++; $display("FAIL rr_resp k=%0d r_id=%h rdata=%h", k, plug_bus.r_id, plug_bus.r_rdata[1]); end
      end
      step();
    end
    per_bus.r_valid = 1'b0;
  endtask
  task automatic test_stall_priority();
    plug_bus.req = 2'b01;
    per_bus.gnt = 1'b1;
    #1;
    checks++; if (plug_bus.gnt !== 2'b01) begin failures++; $display("FAIL sp_pre_gnt got=%b exp=01", plug_bus.gnt); end
    step();
    plug_bus.req = 2'b10;
    per_bus.gnt = 1'b0;
    per_bus.r_valid = 1'b1;
    per_bus.r_id[0] = ID0;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b01) begin failures++; $display("FAIL sp_resp0 got=%b exp=01", plug_bus.r_valid); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (per_bus.req !== 1'b1 || per_bus.add[0] !== A1 || plug_bus.gnt !== 2'b00) begin failures++; $display("FAIL sp_stall k=%0d req=%b add=%h gnt=%b exp 1/%h/00", k, per_bus.req, per_bus.add[0], plug_bus.gnt, A1); end
      step();
      per_bus.r_valid = 1'b0;
    end
    plug_bus.req = 2'b11;
    per_bus.gnt = 1'b1;
    #1;
    checks++; if (plug_bus.gnt !== 2'b10) begin failures++; $display("FAIL sp_held_winner got=%b exp=10", plug_bus.gnt); end
    step();
    checks++; if (dut.rr_ptr !== 1'b0) begin failures++; $display("FAIL sp_ptr got=%0d exp=0", dut.rr_ptr); end
    #1;
    checks++; if (plug_bus.gnt !== 2'b01) begin failures++; $display("FAIL sp_next_gnt got=%b exp=01", plug_bus.gnt); end
    step();
    plug_bus.req = 2'b00;
    per_bus.r_valid = 1'b1;
    per_bus.r_id[0] = ID1;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b10) begin failures++; $display("FAIL sp_drain1 got=%b exp=10", plug_bus.r_valid); end
    step();
    per_bus.r_id[0] = ID0;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b01) begin failures++; $display("FAIL sp_drain0 got=%b exp=01", plug_bus.r_valid); end
    step();
    per_bus.r_valid = 1'b0;
  endtask
  task automatic test_full();
    plug_bus.req = 2'b11;
    per_bus.gnt = 1'b1;
    #1;
    checks++; if (plug_bus.gnt !== 2'b10) begin failures++; $display("FAIL fu_gnt_a got=%b exp=10", plug_bus.gnt); end
    step();
    checks++; if (plug_bus.gnt !== 2'b01) begin failures++; $display("FAIL fu_gnt_b got=%b exp=01", plug_bus.gnt); end
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (per_bus.req !== 1'b0 || plug_bus.gnt !== 2'b00 || dut.u_fifo.cnt !== 2'd2) begin failures++; $display("FAIL fu_blocked k=%0d req=%b gnt=%b cnt=%0d exp 0/00/2", k, per_bus.req, plug_bus.gnt, dut.u_fifo.cnt); end
      step();
    end
    per_bus.r_valid = 1'b1;
    per_bus.r_id[0] = ID1;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b10 || per_bus.req !== 1'b1 || plug_bus.gnt !== 2'b10) begin failures++; $display("FAIL fu_push_pop r_valid=%b req=%b gnt=%b exp 10/1/10", plug_bus.r_valid, per_bus.req, plug_bus.gnt); end
    step();
    per_bus.r_valid = 1'b0;
    #1;
    checks++; if (dut.u_fifo.cnt !== 2'd2 || per_bus.req !== 1'b0) begin failures++; $display("FAIL fu_occupancy cnt=%0d req=%b exp 2/0", dut.u_fifo.cnt, per_bus.req); end
    step();
    plug_bus.req = 2'b00;
    per_bus.r_valid = 1'b1;
    per_bus.r_id[0] = ID0;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b01) begin failures++; $display("FAIL fu_drain0 got=%b exp=01", plug_bus.r_valid); end
    step();
    per_bus.r_id[0] = ID1;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b10) begin failures++; $display("FAIL fu_drain1 got=%b exp=10", plug_bus.r_valid); end
    step();
    per_bus.r_valid = 1'b0;
    #1;
    checks++; if (dut.u_fifo.cnt !== 2'd0) begin failures++; $display("FAIL fu_empty cnt=%0d exp=0", dut.u_fifo.cnt); end
  endtask
  task automatic test_empty_error();
    step();
    checks++; if (dut.err !== 1'b0) begin failures++; $display("FAIL er_pre got=%b exp=0", dut.err); end
    per_bus.r_valid = 1'b1;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b00) begin failures++; $display("FAIL er_r_valid got=%b exp=00", plug_bus.r_valid); end
    step();
    per_bus.r_valid = 1'b0;
    #1;
    checks++; if (dut.err !== 1'b1) begin failures++; $display("FAIL er_sticky got=%b exp=1", dut.err); end
  endtask
  task automatic test_reset_midflight();
    step();
    plug_bus.req = 2'b11;
    per_bus.gnt = 1'b1;
    step();
    step();
    plug_bus.req = 2'b01;
    per_bus.r_valid = 1'b1;
    per_bus.r_id[0] = ID0;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b01 || plug_bus.gnt !== 2'b01) begin failures++; $display("FAIL rm_fill r_valid=%b gnt=%b exp 01/01", plug_bus.r_valid, plug_bus.gnt); end
    step();
    plug_bus.req = 2'b00;
    per_bus.r_valid = 1'b0;
    #1;
    checks++; if (dut.rr_ptr !== 1'b1 || dut.u_fifo.cnt !== 2'd2) begin failures++; $display("FAIL rm_pre ptr=%0d cnt=%0d exp 1/2", dut.rr_ptr, dut.u_fifo.cnt); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    checks++; if (dut.u_fifo.cnt !== 2'd0 || dut.rr_ptr !== 1'b0 || dut.err !== 1'b0 || per_bus.req !== 1'b0) begin failures++; $display("FAIL rm_flushed cnt=%0d ptr=%0d err=%b req=%b exp 0/0/0/0", dut.u_fifo.cnt, dut.rr_ptr, dut.err, per_bus.req); end
    per_bus.r_valid = 1'b1;
    per_bus.r_id[0] = ID1;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b00) begin failures++; $display("FAIL rm_late got=%b exp=00", plug_bus.r_valid); end
    step();
    per_bus.r_valid = 1'b0;
    plug_bus.req = 2'b11;
    #1;
    checks++; if (plug_bus.gnt !== 2'b01) begin failures++; $display("FAIL rm_first_gnt got=%b exp=01", plug_bus.gnt); end
    step();
    plug_bus.req = 2'b00;
    per_bus.r_valid = 1'b1;
    per_bus.r_id[0] = ID0;
    #1;
    checks++; if (plug_bus.r_valid !== 2'b01) begin failures++; $display("FAIL rm_resp got=%b exp=01", plug_bus.r_valid); end
    step();
    per_bus.r_valid = 1'b0;
  endtask
`ifdef SPERIPH_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    plug_bus.req = 2'b01;
    per_bus.gnt = 1'b0;
    #1;
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL sc_reset got=%0d exp=0", stall_cnt); end
    repeat (5) step();
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL sc_five got=%0d exp=5", stall_cnt); end
    plug_bus.req = 2'b00;
    step();
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL sc_hold got=%0d exp=5", stall_cnt); end
  endtask
`endif
  initial begin
    plug_bus.req = 2'b00;
    plug_bus.add = {A1, A0};
    plug_bus.wen = 2'b10;
    plug_bus.wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    plug_bus.be = {4'hC, 4'hF};
    plug_bus.id = {ID1, ID0};
    per_bus.gnt = 1'b0;
    per_bus.r_valid = 1'b0;
    per_bus.r_rdata = '0;
    per_bus.r_opc = 1'b0;
    per_bus.r_id = '0;
    test_reset();
    test_round_robin();
    test_stall_priority();
    test_full();
    test_empty_error();
    test_reset_midflight();
`ifdef SPERIPH_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/speriph_plug_arbiter.md
Name: speriph_plug_arbiter

Overview:
- Merges NB_PLUGS peripheral-interconnect plugs onto one peripheral slave port, for example the event unit's combined slave port or any other multi-plug peripheral.
- Replaces a fixed-priority request mux with fair round-robin arbitration.
- Returns each response to the plug that issued the request, using an in-order tracking FIFO.
- Sits between the peripheral interconnect plugs (upstream) and the peripheral's single XBAR_PERIPH_BUS-style slave (downstream).

Parameters:
- NB_PLUGS, 2, number of upstream plugs (≥2).
- ID_WIDTH, 5, request/response id width (NB_CORES+1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO (power of 2, ≥1).

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous reset, active-high.
- plug_req_i in NB_PLUGS: per-plug request.
- plug_add_i in NB_PLUGS×ADDR_WIDTH: address.
- plug_wen_i in NB_PLUGS: 1 = read, 0 = write.
- plug_wdata_i in NB_PLUGS×DATA_WIDTH: write data.
- plug_be_i in NB_PLUGS×(DATA_WIDTH/8): byte enables.
- plug_id_i in NB_PLUGS×ID_WIDTH: requester id.
- plug_gnt_o out NB_PLUGS: per-plug grant.
- plug_r_valid_o out NB_PLUGS: per-plug response valid.
- plug_r_rdata_o out NB_PLUGS×DATA_WIDTH: response data (broadcast).
- plug_r_opc_o out NB_PLUGS: response error flag (broadcast).
- plug_r_id_o out NB_PLUGS×ID_WIDTH: response id (broadcast).
- per_req_o out 1, per_add_o out ADDR_WIDTH, per_wen_o out 1, per_wdata_o out DATA_WIDTH, per_be_o out DATA_WIDTH/8, per_id_o out ID_WIDTH: downstream request.
- per_gnt_i in 1: downstream grant.
- per_r_valid_i in 1, per_r_rdata_i in DATA_WIDTH, per_r_opc_i in 1, per_r_id_i in ID_WIDTH: downstream response.

Behaviour:
- Reset values:
  - All outputs are 0, with request fields driven from plug 0.
  - Round-robin pointer resets to 0.
  - FIFO is empty.
- Arbitration is combinational within the cycle:
  - Winner is the first requesting plug at or after rr_ptr, searching cyclically.
  - per_req_o = |plug_req_i & ~fifo_full.
  - All request fields are muxed from the winner.
  - No request → fields come from plug 0 and per_req_o = 0.
- Grant:
  - plug_gnt_o[winner] = per_gnt_i & per_req_o; all other grants are 0.
  - A handshake happens when per_req_o & per_gnt_i are both high in the same cycle.
- Pointer update:
  - On a handshake, rr_ptr ← winner+1 mod NB_PLUGS (registered).
  - With no handshake, rr_ptr holds, so a stalled winner keeps priority until it is granted.
- Tracking FIFO:
  - On a handshake, push the winner index.
  - When per_r_valid_i = 1, pop the head and set plug_r_valid_o[head] = 1 in the same cycle (zero latency).
  - r_rdata, r_opc and r_id are broadcast to all plugs unmodified.
- Simultaneous push and pop:
  - Allowed, including when the FIFO is full.
  - Occupancy is unchanged.
  - per_req_o may be asserted when full only if per_r_valid_i = 1 in that cycle.
- Full:
  - When full and no pop is happening, per_req_o = 0 and all grants are 0.
  - Plugs must keep their requests held.
- Empty:
  - per_r_valid_i = 1 while empty is a protocol error.
  - No plug_r_valid_o is raised.
  - A sticky internal error bit is set; it is checked by assertion.
- Downstream timing assumption: the peripheral returns responses in order, at ≥1 cycle after grant.
- Reset asserted mid-transaction: FIFO flushed, pointer returns to 0, outstanding responses are discarded.

Optional Feature:
- Macro: SPERIPH_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (32 bits).
  - The counter increments every cycle in which |plug_req_i = 1 and no handshake occurs.
  - It saturates at 0xFFFF_FFFF and is cleared by rst_i.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package speriph_arb_pkg:
  - Typedef plug_idx_t = logic [$clog2(NB_PLUGS)-1:0].
  - Function rr_next(ptr, req) returning the winner index.
- Sub-module speriph_arb_resp_fifo:
  - Parameterised by depth and width.
  - Push, pop, full, empty, head.
  - Supports concurrent push and pop when full.

Test Plan:
1. Both plugs request continuously, per_gnt_i = 1, and each response arrives 1 cycle after its grant → grants alternate 0,1,0,1; each r_valid goes to the matching plug, and r_id equals the issuing plug_id.
2. Plug 1 is held while per_gnt_i = 0 for 3 cycles, then plug 0 also requests → plug 1 is granted first on the cycle per_gnt_i rises; rr_ptr = 0 afterwards.
3. MAX_OUTSTANDING = 2, per_gnt_i = 1, responses withheld → two grants are issued, then per_req_o = 0; a single response then gives pop plus push in the same cycle, and occupancy stays 2.
4. per_r_valid_i pulse while the FIFO is empty → all plug_r_valid_o stay 0 and the error bit sets.
5. rst_i asserted with 2 responses outstanding → the FIFO empties, late per_r_valid_i is routed nowhere, and the next grant goes to plug 0.
6. With SPERIPH_ARB_STALL_CNT_EN defined, 5 cycles of request with per_gnt_i = 0 → stall_cnt_o = 5.
